// File: rtl/lut_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lut_sweep_ctrl_pkg
//  Brief    : Shared widths, state encoding and constants for the LUT sweeper
//  Revision : 1.0  initial release
// ============================================================================
package lut_sweep_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 6;
    localparam int MASK_W = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MASK_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lut_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lut_sweep_ctrl_if
//  Brief    : Address/select/response bus between sweeper and lookup stage
//  Revision : 1.0  initial release
// ============================================================================
interface lut_sweep_ctrl_if;
    import lut_sweep_ctrl_pkg::*;

    logic [ADDR_W-1:0] lut_a;
    logic [SEL_W-1:0]  lut_s;
    logic              lut_out;

    modport master (
        output lut_a,
        output lut_s,
        input  lut_out
    );

    modport slave (
        input  lut_a,
        input  lut_s,
        output lut_out
    );

endinterface
`default_nettype wire

// File: rtl/lut_sweep_accum.sv
`default_nettype none
// ============================================================================
//  Module   : lut_sweep_accum
//  Brief    : Accumulates lookup hits into mask, count and first-hit index
//  Revision : 1.0  initial release
// ============================================================================
module lut_sweep_accum
    import lut_sweep_ctrl_pkg::*;
(
    input  wire                clk,
    input  wire                rst,
    input  wire                clear,
    input  wire                enable,
    input  wire [ADDR_W-1:0]   addr,
    input  wire                hit,
    output logic [MASK_W-1:0]  hit_mask,
    output logic [CNT_W-1:0]   hit_count,
    output logic [ADDR_W-1:0]  first_hit,
    output logic               any_hit
);

    logic [MASK_W-1:0] r_mask;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_first;
    logic              r_any;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_mask  <= '0;
            r_count <= '0;
            r_first <= '0;
            r_any   <= 1'b0;
        end else if (enable && hit) begin
            r_mask[addr] <= 1'b1;
            r_count      <= r_count + 1'b1;
            // Only the first hit of a sweep fixes the index
            if (!r_any) begin
                r_first <= addr;
                r_any   <= 1'b1;
            end
        end
    end

    assign hit_mask  = r_mask;
    assign hit_count = r_count;
    assign first_hit = r_first;
    assign any_hit   = r_any;

endmodule
`default_nettype wire

// File: rtl/lut_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lut_sweep_ctrl
//  Brief    : Sweeps the lookup address 0..LAST_ADDR and gathers the responses
//  Revision : 1.0  initial release
// ============================================================================
module lut_sweep_ctrl
    import lut_sweep_ctrl_pkg::*;
(
    input  wire                clk,
    input  wire                rst,
    input  wire                start,
    input  wire [SEL_W-1:0]    sel_in,
    input  wire                abort,
    lut_sweep_ctrl_if.master   lut,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [MASK_W-1:0]  hit_mask,
    output logic [CNT_W-1:0]   hit_count,
    output logic [ADDR_W-1:0]  first_hit,
    output logic               any_hit
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [SEL_W-1:0]  r_sel;
    logic              r_aborted;
    logic              w_clear;
    logic              w_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next  = ST_SCAN;
                    w_clear = 1'b1;
                end
            end
            ST_SCAN: begin
                // Abort discards the response sampled in this cycle
                if (abort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_enable = 1'b1;
                    if (r_addr == LAST_ADDR) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_next  = ST_SCAN;
                    w_clear = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_sel     <= '0;
            r_aborted <= 1'b0;
        end else if (w_clear) begin
            r_addr    <= '0;
            r_sel     <= sel_in;
            r_aborted <= 1'b0;
        end else if (r_state == ST_SCAN) begin
            if (abort) begin
                r_aborted <= 1'b1;
            end else if (r_addr != LAST_ADDR) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    lut_sweep_accum u_accum (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .enable    (w_enable),
        .addr      (r_addr),
        .hit       (lut.lut_out),
        .hit_mask  (hit_mask),
        .hit_count (hit_count),
        .first_hit (first_hit),
        .any_hit   (any_hit)
    );

    assign lut.lut_a = r_addr;
    assign lut.lut_s = r_sel;
    assign busy      = (r_state == ST_SCAN);
    assign done      = (r_state == ST_DONE);
    assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_lut_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lut_sweep_ctrl
//  Brief    : Directed self-checking bench for lut_sweep_ctrl with a LUT stub
//  Revision : 1.0  initial release
// ============================================================================
module tb_lut_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  sel_in;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] hit_mask;
    logic [5:0]  hit_count;
    logic [4:0]  first_hit;
    logic        any_hit;
    logic [31:0] r_pattern;

    int tests;
    int fails;

    lut_sweep_ctrl_if bus ();

    assign bus.lut_out = r_pattern[bus.lut_a];

    lut_sweep_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel_in    (sel_in),
        .abort     (abort),
        .lut       (bus),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .hit_mask  (hit_mask),
        .hit_count (hit_count),
        .first_hit (first_hit),
        .any_hit   (any_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input logic [2:0] sel);
        start  = 1'b1;
        sel_in = sel;
        step();
        start  = 1'b0;
    endtask

    task automatic chk_results(input string tag, input logic [31:0] mask,
                               input logic [5:0] cnt, input logic [4:0] first,
                               input logic any);
        chk({tag, "_mask"},  hit_mask,  mask);
        chk({tag, "_count"}, 32'(hit_count), 32'(cnt));
        chk({tag, "_first"}, 32'(first_hit), 32'(first));
        chk({tag, "_any"},   32'(any_hit),   32'(any));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        sel_in    = 3'd0;
        abort     = 1'b0;
        r_pattern = 32'h0;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_lut_a", 32'(bus.lut_a), 32'd0);
        chk("rst_lut_s", 32'(bus.lut_s), 32'd0);
        chk_results("rst", 32'h0, 6'd0, 5'd0, 1'b0);

        // Sweep with hits at 2, 5, 30 and select 5
        r_pattern = 32'h4000_0024;
        start_sweep(3'b101);
        for (int i = 0; i < 32; i++) begin
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_done_low", 32'(done), 32'd0);
            chk("t1_lut_a", 32'(bus.lut_a), 32'(i));
            chk("t1_lut_s", 32'(bus.lut_s), 32'd5);
            step();
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_aborted", 32'(aborted), 32'd0);
        chk_results("t1", 32'h4000_0024, 6'd3, 5'd2, 1'b1);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk_results("t1_hold", 32'h4000_0024, 6'd3, 5'd2, 1'b1);

        // No hits anywhere
        r_pattern = 32'h0;
        start_sweep(3'b000);
        repeat (32) step();
        chk("t2a_done", 32'(done), 32'd1);
        chk_results("t2a", 32'h0, 6'd0, 5'd0, 1'b0);
        step();

        // Hits everywhere
        r_pattern = 32'hFFFF_FFFF;
        start_sweep(3'b010);
        repeat (32) step();
        chk("t2b_done", 32'(done), 32'd1);
        chk_results("t2b", 32'hFFFF_FFFF, 6'd32, 5'd0, 1'b1);
        step();

        // Abort while lut_a = 10
        start_sweep(3'b001);
        repeat (10) step();
        chk("t3_lut_a", 32'(bus.lut_a), 32'd10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_aborted", 32'(aborted), 32'd1);
        chk_results("t3", 32'h0000_03FF, 6'd10, 5'd0, 1'b1);
        step();
        chk("t3_no_done", 32'(done), 32'd0);
        chk("t3_aborted_hold", 32'(aborted), 32'd1);

        // Start pulses mid-sweep are ignored
        r_pattern = 32'h4000_0024;
        start_sweep(3'b101);
        chk("t4_aborted_clr", 32'(aborted), 32'd0);
        for (int i = 0; i < 32; i++) begin
            chk("t4_lut_a", 32'(bus.lut_a), 32'(i));
            chk("t4_lut_s", 32'(bus.lut_s), 32'd5);
            chk("t4_busy", 32'(busy), 32'd1);
            if (i == 7 || i == 12) begin
                start  = 1'b1;
                sel_in = 3'b000;
            end
            step();
            start = 1'b0;
        end
        chk("t4_done", 32'(done), 32'd1);
        chk_results("t4", 32'h4000_0024, 6'd3, 5'd2, 1'b1);

        // Start held through DONE gives an immediate back-to-back sweep
        start_sweep(3'b011);
        chk("t4b_busy", 32'(busy), 32'd1);
        chk("t4b_done", 32'(done), 32'd0);
        chk("t4b_lut_a", 32'(bus.lut_a), 32'd0);
        chk("t4b_lut_s", 32'(bus.lut_s), 32'd3);
        chk_results("t4b", 32'h0, 6'd0, 5'd0, 1'b0);

        // Reset at lut_a = 17
        repeat (17) step();
        chk("t5_lut_a", 32'(bus.lut_a), 32'd17);
        chk("t5_count_pre", 32'(hit_count), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_aborted", 32'(aborted), 32'd0);
        chk("t5_lut_a_rst", 32'(bus.lut_a), 32'd0);
        chk("t5_lut_s_rst", 32'(bus.lut_s), 32'd0);
        chk_results("t5", 32'h0, 6'd0, 5'd0, 1'b0);
        step();
        chk("t5_idle", 32'(busy), 32'd0);

        // Clean sweep after reset
        r_pattern = 32'h8000_0001;
        start_sweep(3'b110);
        for (int i = 0; i < 32; i++) begin
            chk("t5b_busy", 32'(busy), 32'd1);
            step();
        end
        chk("t5b_done", 32'(done), 32'd1);
        chk_results("t5b", 32'h8000_0001, 6'd2, 5'd0, 1'b1);
        step();

        // Abort coincident with the final address
        r_pattern = 32'hFFFF_FFFF;
        start_sweep(3'b111);
        repeat (31) step();
        chk("t6_lut_a", 32'(bus.lut_a), 32'd31);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_aborted", 32'(aborted), 32'd1);
        chk_results("t6", 32'h7FFF_FFFF, 6'd31, 5'd0, 1'b1);
        step();
        chk("t6_no_done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lut_sweep_ctrl.md
Name: lut_sweep_ctrl

Overview:
Sequencer that drives the 5-bit address and 3-bit select inputs of the decoder-based lookup stage and consumes its single-bit output. On a start request it latches a select code and sweeps the address 0..31, one address per cycle. It accumulates the lookup response into a 32-bit membership mask, a hit count and a first-hit index. Handshake is start/busy/done, with abort.

Parameters:
ADDR_W, 5, lookup address width; sweep length is 2**ADDR_W
SEL_W, 3, lookup select width
CNT_W, 6, hit counter width; must equal ADDR_W+1

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a sweep; sampled only in IDLE or DONE
sel_in  in  SEL_W  select code, captured on the accepted start edge
abort  in  1  terminate an in-progress sweep
lut_a  out  ADDR_W  address driven to the lookup stage
lut_s  out  SEL_W  select driven to the lookup stage
lut_out  in  1  lookup response, combinational from lut_a/lut_s
busy  out  1  high while sweeping
done  out  1  one-cycle pulse when a full sweep completes
aborted  out  1  sticky, set by abort, cleared by next accepted start
hit_mask  out  2**ADDR_W  bit i = lut_out sampled while lut_a == i
hit_count  out  CNT_W  number of set bits in hit_mask
first_hit  out  ADDR_W  lowest address with a hit; 0 if none
any_hit  out  1  hit_count != 0

Behaviour:
- Reset (rst=1 at an edge): state IDLE. lut_a=0, lut_s=0, busy=0, done=0, aborted=0, hit_mask=0, hit_count=0, first_hit=0, any_hit=0. Applies in every state, including mid-sweep.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 at an edge moves to SCAN. Same edge: lut_s<=sel_in, lut_a<=0, hit_mask/hit_count/first_hit/any_hit cleared, aborted<=0.
- SCAN: busy=1. Each cycle the block samples lut_out at the clock edge. The lookup path is combinational, so sampling is zero-latency.
  - Sampled 1: hit_mask[lut_a]<=1, hit_count+=1.
  - Sampled 1 with any_hit=0: first_hit<=lut_a, any_hit<=1.
  - lut_a increments each cycle.
  - The edge that samples lut_a=31 moves to DONE. lut_a does not wrap; it holds 31.
- DONE: exactly one cycle. done=1, busy=0. Next edge goes to IDLE, or straight to SCAN if start=1 (back-to-back sweeps, same clearing rules as IDLE).
- Timing, with start accepted at edge k: addresses 0..31 occupy cycles k+1..k+32, and done is high in cycle k+33. Total 33 cycles from start to done.
- start while busy: ignored; sel_in changes mid-sweep have no effect.
- abort=1 in SCAN: the current cycle's lut_out is not recorded. Next state is IDLE, aborted<=1, done stays 0. Partial results are held. abort outside SCAN: ignored.
- abort and the final address (lut_a=31) in the same cycle: abort wins; no done, bit 31 not recorded.
- Results are held stable from DONE/abort until the next accepted start.
- hit_count saturation is impossible by construction (max 32 fits in CNT_W=6).

Decomposition:
- Shared package: state enum (IDLE/SCAN/DONE, 2-bit encoding 00/01/10), ADDR_W/SEL_W/CNT_W constants, LAST_ADDR = 2**ADDR_W-1.
- One natural sub-module: lut_sweep_accum. It holds hit_mask, hit_count, first_hit and any_hit, with clear/enable/addr/bit inputs.
- The FSM and address counter stay in the top level.

Test Plan:
- Lookup stub returns 1 for A in {2,5,30}; start with sel_in=3'b101 at edge 0. Required: busy cycles 1..32, lut_s=5 throughout, done high in cycle 33 only, hit_mask=32'h40000024, hit_count=3, first_hit=2, any_hit=1, aborted=0.
- Stub returns 0 everywhere. Required: hit_mask=0, hit_count=0, first_hit=0, any_hit=0, done at cycle 33. Then stub returns 1 everywhere: hit_mask=32'hFFFFFFFF, hit_count=32, first_hit=0.
- Abort asserted while lut_a=10, stub returns 1 for all A. Required: IDLE next cycle, no done pulse, aborted=1, hit_mask=32'h000003FF, hit_count=10.
- start pulses mid-sweep with sel_in=0. Required: ignored, lut_s unchanged, sweep completes at cycle 33. start held during the DONE cycle: new sweep begins at lut_a=0 next cycle, results cleared, aborted cleared.
- rst asserted at lut_a=17. Required: next cycle all outputs at reset values, state IDLE. A subsequent start gives a full clean 33-cycle sweep.
- Abort and lut_a=31 in the same cycle. Required: done never asserts, aborted=1, hit_mask bit 31 = 0.
